// File: rtl/collision_pkg.sv
// Shared types for the collision path: hit-edge code layout and controller states.
// Also used by the bitmap stages and the game controller.
package collision_pkg;

  // Hit-edge code bit order, MSB to LSB: {Left, Top, Right, Bottom}
  typedef logic [3:0] edge_code_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  // SYNC: waiting for the first frame boundary after reset.
  // ACCUM: collecting per-pixel hits for the current frame.
  // REPORT: one-cycle pulse to the game logic.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } coll_state_t;

endpackage

// File: rtl/frame_hit_accumulator.sv
// Per-frame hit accumulators: edge OR, saturating hit counter, sticky border flag.
// hold_clear_i forces everything to zero. load_i marks the first pixel of a new
// frame: the accumulators restart from that pixel's own contribution rather than
// from zero, so a hit coinciding with the frame boundary is not lost.
module frame_hit_accumulator
  import collision_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               hold_clear_i,
  input  logic               load_i,
  input  logic               level_hit_i,
  input  logic               border_hit_i,
  input  edge_code_t         edge_i,
  output edge_code_t         acc_edges_o,
  output logic [COUNT_W-1:0] acc_count_o,
  output logic               acc_border_o
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  edge_code_t         edges_q, edges_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               border_q, border_d;

  // Next accumulator values: clear, restart on frame boundary, or accumulate.
  always_comb begin
    edges_d  = edges_q;
    count_d  = count_q;
    border_d = border_q;
    if (hold_clear_i) begin
      edges_d  = '0;
      count_d  = '0;
      border_d = 1'b0;
    end else if (load_i) begin
      edges_d  = level_hit_i ? edge_i : '0;
      count_d  = level_hit_i ? ONE : '0;
      border_d = border_hit_i;
    end else begin
      if (level_hit_i) begin
        edges_d = edges_q | edge_i;
        // Saturate at all-ones rather than wrap.
        if (count_q != '1) count_d = count_q + ONE;
      end
      if (border_hit_i) border_d = 1'b1;
    end
  end

  // Accumulator registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edges_q  <= '0;
      count_q  <= '0;
      border_q <= 1'b0;
    end else begin
      edges_q  <= edges_d;
      count_q  <= count_d;
      border_q <= border_d;
    end
  end

  assign acc_edges_o  = edges_q;
  assign acc_count_o  = count_q;
  assign acc_border_o = border_q;

endmodule

// File: rtl/level_collision_ctrl.sv
// Frame-based collision controller: detects player/level and player/border
// overlap per pixel, accumulates over a frame, and reports once per frame at
// the next startOfFrame. There is no backpressure: the consumer samples the
// report outputs on the cycle collisionPulse is high; they then hold until the
// next startOfFrame.
module level_collision_ctrl
  import collision_pkg::*;
#(
  parameter int COUNT_W    = 8,
  parameter int MIN_PIXELS = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               playerDR,
  input  logic               levelDR,
  input  edge_code_t         levelHitEdge,
  input  logic               borderDR,
  output logic               collisionPulse,
  output edge_code_t         collisionEdges,
  output logic               borderHit,
  output logic [COUNT_W-1:0] collisionCount
);

  localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_PIXELS);

  coll_state_t        state_q, state_d;
  logic               level_hit, border_hit, hold_clear, report_ok;
  edge_code_t         acc_edges;
  logic [COUNT_W-1:0] acc_count;
  logic               acc_border;
  edge_code_t         edges_q;
  logic [COUNT_W-1:0] count_q;
  logic               border_q;

  // enable only masks pixels; frame boundaries are always honoured.
  assign level_hit  = playerDR & levelDR & enable;
  assign border_hit = playerDR & borderDR & enable;
  // Accumulators stay at zero until the first frame boundary arms the block.
  assign hold_clear = (state_q == SYNC) & ~startOfFrame;
  assign report_ok  = (acc_count >= MIN_CNT);

  frame_hit_accumulator #(
    .COUNT_W (COUNT_W)
  ) u_acc (
    .clk          (clk),
    .resetN       (resetN),
    .hold_clear_i (hold_clear),
    .load_i       (startOfFrame),
    .level_hit_i  (level_hit),
    .border_hit_i (border_hit),
    .edge_i       (levelHitEdge),
    .acc_edges_o  (acc_edges),
    .acc_count_o  (acc_count),
    .acc_border_o (acc_border)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= SYNC;
    else         state_q <= state_d;
  end

  // Next-state logic; a frame boundary during REPORT keeps the pulse going.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (startOfFrame) state_d = ACCUM;
      ACCUM:   if (startOfFrame && report_ok) state_d = REPORT;
      REPORT:  state_d = startOfFrame ? REPORT : ACCUM;
      default: state_d = SYNC;
    endcase
  end

  // FSM output: the pulse is exactly the REPORT state.
  always_comb begin
    collisionPulse = (state_q == REPORT);
  end

  // Report registers, updated only on frame boundaries once armed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edges_q  <= '0;
      count_q  <= '0;
      border_q <= 1'b0;
    end else if (startOfFrame && state_q != SYNC) begin
      if (state_q == REPORT || report_ok) begin
        edges_q  <= acc_edges;
        count_q  <= acc_count;
        border_q <= acc_border;
      end else begin
        // Too few level hits: still report the border result.
        edges_q  <= '0;
        count_q  <= '0;
        border_q <= acc_border;
      end
    end
  end

  assign collisionEdges = edges_q;
  assign collisionCount = count_q;
  assign borderHit      = border_q;

endmodule

// File: tb/tb_level_collision_ctrl.sv
// Bench for level_collision_ctrl: frame-level reference model, per-cycle
// output compare, directed scenarios with literal expectations, then random
// pixel traffic.
module tb_level_collision_ctrl;
  import collision_pkg::*;

  localparam int COUNT_W    = 8;
  localparam int MIN_PIXELS = 1;
  localparam int CMAX       = (1 << COUNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  logic               startOfFrame, enable, playerDR, levelDR, borderDR;
  edge_code_t         levelHitEdge;
  logic               collisionPulse, borderHit;
  edge_code_t         collisionEdges;
  logic [COUNT_W-1:0] collisionCount;

  level_collision_ctrl #(
    .COUNT_W    (COUNT_W),
    .MIN_PIXELS (MIN_PIXELS)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .playerDR       (playerDR),
    .levelDR        (levelDR),
    .levelHitEdge   (levelHitEdge),
    .borderDR       (borderDR),
    .collisionPulse (collisionPulse),
    .collisionEdges (collisionEdges),
    .borderHit      (borderHit),
    .collisionCount (collisionCount)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // Frame statistics are only collected once a frame boundary has been seen
  // after reset; each boundary decides what the report outputs become.
  bit         m_armed;
  int         m_count;
  logic [3:0] m_edges;
  bit         m_border;
  bit         e_pulse;
  logic [3:0] e_edges;
  int         e_count;
  bit         e_border;
  bit         px_lvl, px_bdr;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_armed = 0; m_count = 0; m_edges = '0; m_border = 0;
      e_pulse = 0; e_edges = '0; e_count = 0; e_border = 0;
    end else begin
      px_lvl = playerDR && levelDR && enable;
      px_bdr = playerDR && borderDR && enable;
      if (startOfFrame) begin
        if (m_armed) begin
          // A boundary during a report always reports; otherwise needs MIN_PIXELS.
          if (e_pulse || m_count >= MIN_PIXELS) begin
            e_pulse = 1; e_edges = m_edges; e_count = m_count; e_border = m_border;
          end else begin
            e_pulse = 0; e_edges = '0; e_count = 0; e_border = m_border;
          end
        end else begin
          e_pulse = 0;
        end
        m_armed  = 1;
        m_count  = px_lvl ? 1 : 0;
        m_edges  = px_lvl ? levelHitEdge : 4'h0;
        m_border = px_bdr;
      end else begin
        e_pulse = 0;
        if (m_armed) begin
          if (px_lvl) begin
            m_edges = m_edges | levelHitEdge;
            if (m_count < CMAX) m_count = m_count + 1;
          end
          if (px_bdr) m_border = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("pulse",  {31'd0, collisionPulse}, {31'd0, e_pulse});
    check("edges",  {28'd0, collisionEdges}, {28'd0, e_edges});
    check("count",  32'(collisionCount),     32'(e_count));
    check("border", {31'd0, borderHit},      {31'd0, e_border});
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge and are consumed at the next one.
  task automatic drive(input logic sof, input logic en, input logic p, input logic l,
                       input logic [3:0] e, input logic b);
    startOfFrame = sof; enable = en; playerDR = p; levelDR = l;
    levelHitEdge = e; borderDR = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 4'h0, 0);
  endtask

  task automatic hits(input int n, input logic [3:0] e);
    for (int i = 0; i < n; i++) drive(0, 1, 1, 1, e, 0);
  endtask

  task automatic sof();
    drive(1, 1, 0, 0, 4'h0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetN = 1'b0;
    startOfFrame = 0; enable = 0; playerDR = 0; levelDR = 0; borderDR = 0;
    levelHitEdge = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse",  {31'd0, collisionPulse}, 32'd0);
    check("rst_edges",  {28'd0, collisionEdges}, 32'd0);
    check("rst_count",  32'(collisionCount),     32'd0);
    check("rst_border", {31'd0, borderHit},      32'd0);
    resetN = 1'b1;

    // Partial frame after reset: hit is ignored, first boundary only arms.
    hits(1, 4'h8); idle(2);
    sof();
    check("arm_no_pulse", {31'd0, collisionPulse}, 32'd0);
    hits(1, 4'h8); idle(3);
    sof();
    check("f2_pulse", {31'd0, collisionPulse}, 32'd1);
    check("f2_edges", {28'd0, collisionEdges}, 32'h8);
    check("f2_count", 32'(collisionCount),     32'd1);
    idle(1);
    check("f2_pulse_end", {31'd0, collisionPulse}, 32'd0);
    check("f2_hold",      32'(collisionCount),     32'd1);

    // Edge OR across three pixels.
    hits(1, 4'h4); idle(1); hits(1, 4'h2); hits(1, 4'h4); idle(2);
    sof();
    check("or_edges", {28'd0, collisionEdges}, 32'h6);
    check("or_count", 32'(collisionCount),     32'd3);

    // Saturation.
    hits(300, 4'h1);
    sof();
    check("sat_count", 32'(collisionCount),     32'd255);
    check("sat_pulse", {31'd0, collisionPulse}, 32'd1);

    // Hit on the boundary belongs to the new frame.
    idle(3);
    drive(1, 1, 1, 1, 4'h2, 0);
    check("sofhit_nopulse", {31'd0, collisionPulse}, 32'd0);
    check("sofhit_count0",  32'(collisionCount),     32'd0);
    idle(4);
    sof();
    check("sofhit_pulse", {31'd0, collisionPulse}, 32'd1);
    check("sofhit_count", 32'(collisionCount),     32'd1);
    check("sofhit_edges", {28'd0, collisionEdges}, 32'h2);

    // Border-only overlap.
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 4'h0, 1);
    sof();
    check("bdr_hit",   {31'd0, borderHit},      32'd1);
    check("bdr_pulse", {31'd0, collisionPulse}, 32'd0);
    check("bdr_edges", {28'd0, collisionEdges}, 32'd0);

    // Same overlaps masked by enable low.
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 4'hF, 1);
    sof();
    check("dis_border", {31'd0, borderHit},      32'd0);
    check("dis_pulse",  {31'd0, collisionPulse}, 32'd0);

    // Back-to-back boundaries extend the pulse.
    hits(2, 4'h1);
    sof();
    check("b2b_pulse1", {31'd0, collisionPulse}, 32'd1);
    check("b2b_count1", 32'(collisionCount),     32'd2);
    sof();
    check("b2b_pulse2", {31'd0, collisionPulse}, 32'd1);
    check("b2b_count2", 32'(collisionCount),     32'd0);
    idle(1);
    check("b2b_end", {31'd0, collisionPulse}, 32'd0);

    // Mid-frame reset.
    hits(5, 4'h2);
    sof();
    check("pre_rst_count", 32'(collisionCount), 32'd5);
    hits(10, 4'h8);
    resetN = 1'b0;
    #1;
    check("mid_rst_count",  32'(collisionCount),     32'd0);
    check("mid_rst_edges",  {28'd0, collisionEdges}, 32'd0);
    check("mid_rst_pulse",  {31'd0, collisionPulse}, 32'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    idle(3);
    sof();
    check("post_rst_arm", {31'd0, collisionPulse}, 32'd0);
    idle(5);
    sof();
    check("post_rst_nostale", {31'd0, collisionPulse}, 32'd0);
    check("post_rst_count",   32'(collisionCount),     32'd0);

    // Random pixel traffic with occasional frame boundaries.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 5) == 0);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
